// File: rtl/player_sprite_ctrl.sv
// rtl/player_sprite_ctrl.sv - player sprite horizontal position and per-frame draw launch
// Define PLAYER_WRAP_EN to wrap the sprite at the screen edges instead of clamping.
module player_sprite_ctrl #(
  parameter int RES_H  = 640,
  parameter int SPR_Y  = 440,
  parameter int SPR_W  = 32,
  parameter int STEP   = 2,
  parameter int X_INIT = 304
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       freeze,
  input  logic       frame_start,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  output logic [9:0] spr_x,
  output logic       start
);

  localparam logic [10:0] LIM    = 11'(RES_H - SPR_W);
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [9:0]  SPR_YW = 10'(SPR_Y);
  localparam logic [9:0]  X_RST  = 10'(X_INIT);

`ifdef PLAYER_WRAP_EN
  localparam logic [9:0] LEFT_EDGE_X  = 10'(LIM);
  localparam logic [9:0] RIGHT_EDGE_X = 10'd0;
`else
  localparam logic [9:0] LEFT_EDGE_X  = 10'd0;
  localparam logic [9:0] RIGHT_EDGE_X = 10'(LIM);
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOVE,
    ST_ARMED,
    ST_FIRE
  } state_e;

  state_e      state_q, state_d;
  logic        bl_meta_q, bl_s_q;
  logic        br_meta_q, br_s_q;
  logic [9:0]  spr_x_q, spr_x_d;
  logic        start_q;
  logic [10:0] x_ext;
  logic [10:0] x_sum;
  logic        line_match;

  // Two-flop synchronizers for the raw push buttons.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bl_meta_q <= 1'b0;
      bl_s_q    <= 1'b0;
      br_meta_q <= 1'b0;
      br_s_q    <= 1'b0;
    end else begin
      bl_meta_q <= btn_left;
      bl_s_q    <= bl_meta_q;
      br_meta_q <= btn_right;
      br_s_q    <= br_meta_q;
    end
  end

  assign line_match = (pixel_y == SPR_YW) && (pixel_x == 10'd0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (frame_start) state_d = ST_MOVE;
      ST_MOVE:  state_d = ST_ARMED;
      ST_ARMED: begin
        if (frame_start) begin
          state_d = ST_MOVE;
        end else if (line_match) begin
          state_d = ST_FIRE;
        end
      end
      ST_FIRE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // 11-bit arithmetic keeps spr_x + STEP from wrapping before the limit test.
  always_comb begin
    x_ext   = {1'b0, spr_x_q};
    x_sum   = x_ext + STEP_W;
    spr_x_d = spr_x_q;
    if ((state_q == ST_MOVE) && !freeze && (bl_s_q != br_s_q)) begin
      if (bl_s_q) begin
        if (x_ext < STEP_W) begin
          spr_x_d = LEFT_EDGE_X;
        end else begin
          spr_x_d = 10'(x_ext - STEP_W);
        end
      end else begin
        if (x_sum > LIM) begin
          spr_x_d = RIGHT_EDGE_X;
        end else begin
          spr_x_d = 10'(x_sum);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      spr_x_q <= X_RST;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      spr_x_q <= spr_x_d;
      start_q <= (state_d == ST_FIRE);
    end
  end

  assign spr_x = spr_x_q;
  assign start = start_q;

endmodule
